// File: rtl/sdpram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdpram_arb_pkg
// Shared types and constants for the two-requester SDP-RAM read arbiter:
// FSM state encoding, default bus widths, legal RAM read latencies, the
// round-robin reset value and a small id-to-one-hot helper.
// ---------------------------------------------------------------------------
package sdpram_arb_pkg;

  localparam int ARB_ADDR_W   = 10;
  localparam int ARB_DATA_W   = 8;
  localparam int ARB_LEN_W    = 8;

  // Legal RAM read latencies: bare array, or array plus output register.
  localparam int RD_LAT_NOREG = 1;
  localparam int RD_LAT_OREG  = 2;

  // "Last served" resets to requester 1 so requester 0 wins the first tie.
  localparam logic RR_LAST_RST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } arb_state_e;

  function automatic logic [1:0] id2oh(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdpram_rd_lat_pipe.sv
// ---------------------------------------------------------------------------
// sdpram_rd_lat_pipe
// Delay line carrying the "address issued" flag and its owner id alongside
// the RAM read, so they line up with ram_rd_data DEPTH cycles later.
// Ports:
//   rd_clk_tb  in   clock
//   tb_rst     in   async active-high clear (drops any in-flight words)
//   i_vld/i_id in   address issued this cycle / owner
//   o_vld/o_id out  same, delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module sdpram_rd_lat_pipe
  import sdpram_arb_pkg::*;
#(
  parameter int DEPTH = RD_LAT_NOREG
) (
  input  logic rd_clk_tb,
  input  logic tb_rst,
  input  logic i_vld,
  input  logic i_id,
  output logic o_vld,
  output logic o_id
);

  logic [DEPTH:1] r_vld_pipe;
  logic [DEPTH:1] r_id_pipe;

  always_ff @(posedge rd_clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
    end else begin
      r_vld_pipe[1] <= i_vld;
      r_id_pipe[1]  <= i_id;
      for (int s = 2; s <= DEPTH; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_id_pipe[s]  <= r_id_pipe[s-1];
      end
    end
  end

  assign o_vld = r_vld_pipe[DEPTH];
  assign o_id  = r_id_pipe[DEPTH];

endmodule

// File: rtl/sdpram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// sdpram_rd_arbiter
// Round-robin burst read arbiter in front of a simple dual-port RAM read port.
// Two requesters each ask for a burst (start address + word count); the
// winner gets a one-cycle gnt, its addresses are streamed one per cycle, the
// returned words come back tagged with rd_id, and done pulses once the last
// word has been delivered.
// Ports:
//   rd_clk_tb, tb_rst          clock, async active-high reset
//   req[1:0]                   burst requests (held until gnt)
//   start_addr0/1, len0/1      burst parameters per requester
//   gnt[1:0]                   one-hot grant pulse
//   ram_rd_addr, ram_rd_data   RAM read port (address registered)
//   rd_valid, rd_data, rd_id   returned word, registered
//   done[1:0]                  burst-complete pulse
//   busy                       FSM not idle
// RD_LATENCY must be 1 or 2 (RAM without / with output register).
// ---------------------------------------------------------------------------
module sdpram_rd_arbiter
  import sdpram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_W,
  parameter int DATA_WIDTH = ARB_DATA_W,
  parameter int LEN_WIDTH  = ARB_LEN_W,
  parameter int RD_LATENCY = RD_LAT_NOREG
) (
  input  logic                  rd_clk_tb,
  input  logic                  tb_rst,
  input  logic [1:0]            req,
  input  logic [ADDR_WIDTH-1:0] start_addr0,
  input  logic [ADDR_WIDTH-1:0] start_addr1,
  input  logic [LEN_WIDTH-1:0]  len0,
  input  logic [LEN_WIDTH-1:0]  len1,
  output logic [1:0]            gnt,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_id,
  output logic [1:0]            done,
  output logic                  busy
);

  arb_state_e            r_state, w_state_nxt;
  logic                  r_last;    // requester served by the previous burst
  logic                  r_owner;   // requester of the burst in flight
  logic [LEN_WIDTH-1:0]  r_cnt;     // words left in ISSUE, cycles left in DRAIN
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_gnt, r_done;
  logic                  r_rd_valid, r_rd_id;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_win, w_take, w_issue, w_last_word, w_drain_end;
  logic [1:0]            w_gnt_nxt, w_done_nxt;
  logic [LEN_WIDTH-1:0]  w_len_sel;
  logic [ADDR_WIDTH-1:0] w_addr_sel;
  logic                  w_pipe_vld, w_pipe_id;

  // On a tie the requester not served last wins; otherwise the lone requester.
  assign w_win       = (req == 2'b11) ? ~r_last : req[1];
  assign w_len_sel   = w_win ? len1 : len0;
  assign w_addr_sel  = w_win ? start_addr1 : start_addr0;
  assign w_last_word = (r_cnt == LEN_WIDTH'(1));
  assign w_drain_end = (r_cnt == '0);

  // ---- state register ----
  always_ff @(posedge rd_clk_tb or posedge tb_rst) begin
    if (tb_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---- next state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (|req) w_state_nxt = (w_len_sel == '0) ? ST_FIN : ST_ISSUE;
      ST_ISSUE: if (w_last_word) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drain_end) w_state_nxt = ST_FIN;
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---- outputs (next values of the registered pulses) ----
  always_comb begin
    w_take     = 1'b0;
    w_issue    = 1'b0;
    w_gnt_nxt  = '0;
    w_done_nxt = '0;
    case (r_state)
      ST_IDLE: if (|req) begin
        w_take    = 1'b1;
        w_gnt_nxt = id2oh(w_win);
      end
      ST_ISSUE: w_issue    = 1'b1;
      ST_FIN:   w_done_nxt = id2oh(r_owner);
      default: ;
    endcase
  end

  // ---- burst datapath ----
  always_ff @(posedge rd_clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_owner <= 1'b0;
      r_last  <= RR_LAST_RST;
      r_gnt   <= '0;
      r_done  <= '0;
    end else begin
      r_gnt  <= w_gnt_nxt;
      r_done <= w_done_nxt;
      if (w_take) begin
        r_owner <= w_win;
        r_cnt   <= w_len_sel;
        r_addr  <= w_addr_sel;
      end else if (w_issue) begin
        // Last address stays on the bus; the counter is reused for DRAIN.
        if (w_last_word) begin
          r_cnt <= LEN_WIDTH'(RD_LATENCY - 1);
        end else begin
          r_cnt  <= r_cnt - 1'b1;
          r_addr <= r_addr + 1'b1;
        end
      end else if (r_state == ST_DRAIN && !w_drain_end) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (r_state == ST_FIN) r_last <= r_owner;
    end
  end

  // Issue flag travels with the RAM read so it meets ram_rd_data.
  sdpram_rd_lat_pipe #(.DEPTH(RD_LATENCY)) u_lat_pipe (
    .rd_clk_tb (rd_clk_tb),
    .tb_rst    (tb_rst),
    .i_vld     (w_issue),
    .i_id      (r_owner),
    .o_vld     (w_pipe_vld),
    .o_id      (w_pipe_id)
  );

  always_ff @(posedge rd_clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_id    <= 1'b0;
    end else begin
      r_rd_valid <= w_pipe_vld;
      r_rd_data  <= w_pipe_vld ? ram_rd_data : '0;
      r_rd_id    <= w_pipe_vld ? w_pipe_id : 1'b0;
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign ram_rd_addr = r_addr;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign rd_id       = r_rd_id;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sdpram_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdpram_rd_arbiter
// Two arbiter instances (RD_LATENCY 1 and 2), each with its own RAM model
// holding data = addr[7:0]. A timeline model turns every accepted request
// into the per-cycle gnt/addr/rd_valid/done/busy it must cause, and a
// negedge checker compares each instance against that timeline.
// ---------------------------------------------------------------------------
module tb_sdpram_rd_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 8;
  localparam int LW   = 8;
  localparam int NCYC = 8192;

  logic rd_clk_tb = 1'b0;
  logic tb_rst    = 1'b1;
  always #5 rd_clk_tb = ~rd_clk_tb;

  logic [1:0]    req         [2];
  logic [AW-1:0] sa0         [2];
  logic [AW-1:0] sa1         [2];
  logic [LW-1:0] ln0         [2];
  logic [LW-1:0] ln1         [2];
  logic [1:0]    gnt         [2];
  logic [1:0]    done        [2];
  logic [AW-1:0] ram_rd_addr [2];
  logic [DW-1:0] ram_rd_data [2];
  logic [DW-1:0] rd_data     [2];
  logic          rd_valid    [2];
  logic          rd_id       [2];
  logic          busy        [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // number of rising edges seen; cycle c follows edge c

  // Expected per-cycle behaviour, per lane
  logic [1:0]    e_gnt  [2][NCYC];
  logic [1:0]    e_done [2][NCYC];
  logic          e_vld  [2][NCYC];
  logic          e_id   [2][NCYC];
  logic          e_busy [2][NCYC];
  logic          e_aset [2][NCYC];
  logic [AW-1:0] e_addr [2][NCYC];
  logic [DW-1:0] e_data [2][NCYC];
  int            m_free [2];   // first edge at which the lane may accept again
  logic          m_last [2];   // requester served last
  logic [AW-1:0] m_addr [2];   // address the bus should currently hold

  for (genvar gi = 0; gi < 2; gi++) begin : g_lat
    localparam int LAT = gi + 1;
    logic [DW-1:0] mem [1<<AW];
    logic [DW-1:0] r_q1, r_q2;
    initial for (int i = 0; i < (1<<AW); i++) mem[i] = DW'(i);
    always @(posedge rd_clk_tb) begin
      r_q1 <= mem[ram_rd_addr[gi]];
      r_q2 <= r_q1;
    end
    assign ram_rd_data[gi] = (LAT == 1) ? r_q1 : r_q2;

    sdpram_rd_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .RD_LATENCY(LAT)
    ) u_dut (
      .rd_clk_tb   (rd_clk_tb),
      .tb_rst      (tb_rst),
      .req         (req[gi]),
      .start_addr0 (sa0[gi]),
      .start_addr1 (sa1[gi]),
      .len0        (ln0[gi]),
      .len1        (ln1[gi]),
      .gnt         (gnt[gi]),
      .ram_rd_addr (ram_rd_addr[gi]),
      .ram_rd_data (ram_rd_data[gi]),
      .rd_valid    (rd_valid[gi]),
      .rd_data     (rd_data[gi]),
      .rd_id       (rd_id[gi]),
      .done        (done[gi]),
      .busy        (busy[gi])
    );
  end

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // Clear all expectations from the current cycle on (reset drops bursts).
  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      for (int c = cyc; c < NCYC; c++) begin
        e_gnt[l][c] = '0; e_done[l][c] = '0; e_vld[l][c] = 0; e_id[l][c] = 0;
        e_busy[l][c] = 0; e_aset[l][c] = 0; e_addr[l][c] = '0; e_data[l][c] = '0;
      end
      m_free[l] = 0; m_last[l] = 1'b1; m_addr[l] = '0;
    end
  endtask

  // A request seen at an edge where the lane is free becomes a timeline.
  task automatic model_edge(int l);
    int g, d, lat;
    logic w;
    logic [LW-1:0] n;
    logic [AW-1:0] a, ai;
    if (cyc < m_free[l] || req[l] == 2'b00) return;
    lat = l + 1;
    g   = cyc;
    w   = (req[l] == 2'b11) ? ~m_last[l] : req[l][1];
    n   = w ? ln1[l] : ln0[l];
    a   = w ? sa1[l] : sa0[l];
    e_gnt[l][g]  = w ? 2'b10 : 2'b01;
    e_aset[l][g] = 1; e_addr[l][g] = a;
    for (int i = 0; i < int'(n); i++) begin
      ai = a + AW'(i);
      e_aset[l][g+i] = 1; e_addr[l][g+i] = ai;
      e_vld[l][g+i+lat+1]  = 1;
      e_data[l][g+i+lat+1] = ai[DW-1:0];
      e_id[l][g+i+lat+1]   = w;
    end
    d = (n == 0) ? g + 1 : g + int'(n) + lat + 1;
    e_done[l][d] = w ? 2'b10 : 2'b01;
    for (int c = g; c < d; c++) e_busy[l][c] = 1;
    m_free[l] = d + 1;
    m_last[l] = w;
  endtask

  initial forever begin
    @(posedge rd_clk_tb);
    cyc++;
    if (!tb_rst) for (int l = 0; l < 2; l++) model_edge(l);
  end

  initial forever begin
    @(negedge rd_clk_tb);
    for (int l = 0; l < 2; l++) begin
      if (e_aset[l][cyc]) m_addr[l] = e_addr[l][cyc];
      chk($sformatf("L%0d ctl c%0d", l, cyc),
          32'({gnt[l], done[l], rd_valid[l], busy[l]}),
          32'({e_gnt[l][cyc], e_done[l][cyc], e_vld[l][cyc], e_busy[l][cyc]}));
      chk($sformatf("L%0d addr c%0d", l, cyc), 32'(ram_rd_addr[l]), 32'(m_addr[l]));
      if (e_vld[l][cyc])
        chk($sformatf("L%0d data c%0d", l, cyc),
            32'({rd_id[l], rd_data[l]}), 32'({e_id[l][cyc], e_data[l][cyc]}));
    end
  end

  task automatic chk_zero(string tag);
    for (int j = 0; j < 2; j++)
      chk($sformatf("L%0d %s", j, tag),
          32'({gnt[j], done[j], rd_valid[j], rd_id[j], busy[j], rd_data[j], ram_rd_addr[j]}), 32'd0);
  endtask

  task automatic do_req(int l, int who, logic [AW-1:0] a, logic [LW-1:0] n);
    bit got = 0;
    @(negedge rd_clk_tb); #1;
    if (who == 0) begin sa0[l] = a; ln0[l] = n; end
    else          begin sa1[l] = a; ln1[l] = n; end
    req[l][who] = 1'b1;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge rd_clk_tb); #1;
      if (gnt[l][who]) got = 1;
    end
    req[l][who] = 1'b0;
    chk($sformatf("L%0d gnt_seen r%0d", l, who), 32'(got), 32'd1);
    repeat (int'(n) + l + 8) @(negedge rd_clk_tb);
  endtask

  // Both requesters held high: grants must alternate starting with 0.
  task automatic contend(int l);
    int seen = 0;
    @(negedge rd_clk_tb); #1;
    sa0[l] = 10'h100; ln0[l] = 8'd2; sa1[l] = 10'h200; ln1[l] = 8'd2;
    req[l] = 2'b11;
    for (int k = 0; k < 200 && seen < 4; k++) begin
      @(negedge rd_clk_tb); #1;
      if (gnt[l] != 2'b00) begin
        chk($sformatf("L%0d rr_order %0d", l, seen), 32'(gnt[l]),
            (seen % 2 == 1) ? 32'd2 : 32'd1);
        seen++;
      end
    end
    req[l] = 2'b00;
    chk($sformatf("L%0d rr_count", l), 32'(seen), 32'd4);
    repeat (12) @(negedge rd_clk_tb);
  endtask

  task automatic reset_mid(int l);
    int nv = 0;
    @(negedge rd_clk_tb); #1;
    sa0[l] = 10'h000; ln0[l] = 8'd8; req[l][0] = 1'b1;
    for (int k = 0; k < 100 && nv < 2; k++) begin
      @(negedge rd_clk_tb); #1;
      if (gnt[l][0]) req[l][0] = 1'b0;
      if (rd_valid[l]) nv++;
    end
    req[l] = 2'b00;
    chk($sformatf("L%0d rst_pre_words", l), 32'(nv), 32'd2);
    tb_rst = 1'b1;
    model_reset();
    #1 chk_zero("rst_now");
    repeat (3) @(negedge rd_clk_tb);
    #1 tb_rst = 1'b0;
    do_req(l, 1, 10'h020, 8'd1);
  endtask

  task automatic rnd(int l, int n);
    logic [AW-1:0] a;
    logic [LW-1:0] ln;
    for (int k = 0; k < n; k++) begin
      @(negedge rd_clk_tb); #1;
      for (int b = 0; b < 2; b++) begin
        if (req[l][b]) begin
          if (gnt[l][b] || $urandom_range(0, 19) == 0) req[l][b] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          a  = ($urandom_range(0, 3) == 0) ? AW'(10'h3FB + $urandom_range(0, 4)) : AW'($urandom);
          ln = LW'($urandom_range(0, 6));
          if (b == 0) begin sa0[l] = a; ln0[l] = ln; end
          else        begin sa1[l] = a; ln1[l] = ln; end
          req[l][b] = 1'b1;
        end
      end
    end
    req[l] = 2'b00;
    repeat (20) @(negedge rd_clk_tb);
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      req[l] = '0; sa0[l] = '0; sa1[l] = '0; ln0[l] = '0; ln1[l] = '0;
    end
    model_reset();
    #1 chk_zero("reset_state");
    repeat (2) @(negedge rd_clk_tb);
    #1 tb_rst = 1'b0;
    for (int l = 0; l < 2; l++) begin
      do_req(l, 0, 10'h010, 8'd4);   // single burst
      do_req(l, 1, 10'h3FE, 8'd4);   // address wrap, leaves requester 1 as last
      contend(l);
      do_req(l, 0, 10'h155, 8'd0);   // zero length
      reset_mid(l);
      rnd(l, 800);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
